bus_timer: RTL and testbench
============================

// Module: bus_timer
// PURPOSE
// - Programmable down-counting timer; memory-mapped responder on the south-bridge device port.
// - Decodes the word address, write strobe and write data driven by the south bridge.
// - Returns read data combinationally and raises an interrupt line into HWINT.
// - One instance serves as Timer0 and one as Timer1; only the base address differs, and base decode lives in the bridge.
// PARAMETERS
// - CNT_W  32  width of PRESET/COUNT (1..32); register reads zero-extend to 32b, writes truncate to CNT_W.
// PORTS
// - clk     in   1   system clock, all state on posedge
// - reset   in   1   synchronous, active-high
// - Addr    in   30  word address [31:2]; only Addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS/reserved)
// - WData   in   32  write data
// - WE      in   1   full-word write strobe, already gated by bridge address decode
// - RData   out  32  read data, combinational from Addr[3:2] and current registers
// - IRQ     out  1   interrupt request = CTRL.IM & irq_pend
// BEHAVIOUR
// - CTRL bit fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; bits [31:4] read 0.
// - Reset: CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state=IDLE.
//   Hence IRQ=0, and RData=0 for every Addr during the cycle after reset.
// - Writes (WE=1) take effect at the next posedge.
//   - Addr[3:2]=0 writes CTRL[3:0]. Any CTRL write also clears irq_pend.
//   - Addr[3:2]=1 writes PRESET.
//   - Addr[3:2]=2 and 3 are ignored; COUNT is read-only.
// - FSM, 4 states, one transition per clk:
//   - IDLE: if EN -> LOAD.
//   - LOAD: COUNT<=PRESET; -> CNT.
//   - CNT: if !EN -> IDLE (COUNT holds).
//     Else if COUNT>1: COUNT<=COUNT-1.
//     Else (COUNT is 1 or 0): COUNT<=0, irq_pend<=1, -> INT.
//   - INT, MODE=00: EN<=0, -> IDLE; irq_pend stays 1 until a CTRL write.
//   - INT, MODE=01: irq_pend<=0, -> IDLE. EN remains 1, so the timer reloads automatically.
// - Latency: EN written at cycle t.
//   - COUNT=PRESET is visible at t+2.
//   - irq_pend is set at t+2+max(PRESET-1,0)+1.
//   - PRESET=0 behaves as PRESET=1.
// - Auto-reload period is PRESET+3 clk; IRQ is high for exactly 1 clk per period when IM=1.
// - A CTRL write in the same cycle as FSM-driven EN<=0 (INT, MODE=00): the bus write wins for all CTRL bits.
//   Its irq_pend clear also wins over a simultaneous set.
// - A PRESET write during CNT does not affect COUNT until the next LOAD.
// - Writing EN=0 mid-count freezes COUNT and leaves irq_pend unchanged.
// - IM gates only the IRQ output; irq_pend still updates while IM=0.
// - Reset asserted in any state returns to reset values at the next posedge. Reset has priority over WE.
// CONFIGURATION
// - BUS_TIMER_STATUS_EN defined: Addr[3:2]=3 reads {27'b0, irq_pend, state[1:0] (IDLE=0 LOAD=1 CNT=2 INT=3), IM, EN}.
//   In this mode a write to offset 3 with WData[2]=1 clears irq_pend.
// - BUS_TIMER_STATUS_EN undefined: offset 3 reads 0 and writes are ignored.
// TESTING
// - Reset: assert reset 2 clk with WE=1 -> RData=0 at offsets 0-3, IRQ=0, and no register written.
// - One-shot: PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1,0.
//   IRQ rises 7 clk after the CTRL write; CTRL reads 0x8; IRQ stays 1 until CTRL is written with 0x8.
// - Auto-reload: PRESET=3, CTRL=0xB -> IRQ pulses 1 clk wide every 6 clk for at least 4 periods; EN stays 1.
// - Pause: PRESET=10, EN=1, then write CTRL=0 when COUNT=6 -> COUNT holds 6 for 5 clk.
//   Rewriting CTRL=0x1 -> LOAD, and COUNT reads 10 again.
// - Masked/collision: IM=0 one-shot expiry -> IRQ=0, and STATUS bit4=1 when BUS_TIMER_STATUS_EN is set.
//   A CTRL write in the INT cycle -> the written value is kept.
// - Edge cases: PRESET=0 -> IRQ 3 clk after EN.
//   CNT_W=8 with WData=0x1FF to PRESET -> PRESET reads 0xFF.
//   A write to COUNT -> ignored.

Source files
------------

// File: rtl/bus_timer_if.sv
// bus_timer_if: south-bridge device-port bundle between the bridge (master)
// and a timer responder (slave). Addr is the word address [31:2].
interface bus_timer_if;
    logic [31:2] Addr;
    logic [31:0] WData;
    logic        WE;
    logic [31:0] RData;
    logic        IRQ;

    modport master (output Addr, output WData, output WE, input RData, input IRQ);
    modport slave  (input Addr, input WData, input WE, output RData, output IRQ);
endinterface

// File: rtl/bus_timer.sv
// bus_timer: programmable down-counting timer on the south-bridge device port.
// Offsets (Addr[3:2]): 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only),
// 3 STATUS when BUS_TIMER_STATUS_EN is defined, otherwise reads 0 / ignores writes.
// Optional feature macro: BUS_TIMER_STATUS_EN.
module bus_timer #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    bus_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0]       MODE_RELOAD = 2'b01;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_pend_q, irq_pend_d;
    logic [31:0]        rdata;
    logic               unused_bus;

    // Address bits above the register offset are decoded by the bridge.
    assign unused_bus = ^{bus.Addr[31:4], bus.WData};

    // Register file: reset has priority over any bus write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    // FSM next state, then bus writes layered on top so they win any collision.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    // PRESET=0 expires on the same cycle as PRESET=1.
                    count_d    = '0;
                    irq_pend_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                // Only MODE=01 reloads; 10/11 behave as one-shot.
                if (mode_q == MODE_RELOAD) irq_pend_d = 1'b0;
                else                       en_d       = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.WE) begin
            case (bus.Addr[3:2])
                2'd0: begin
                    en_d       = bus.WData[0];
                    mode_d     = bus.WData[2:1];
                    im_d       = bus.WData[3];
                    irq_pend_d = 1'b0;
                end
                2'd1: preset_d = bus.WData[CNT_W-1:0];
                2'd3: begin
`ifdef BUS_TIMER_STATUS_EN
                    if (bus.WData[2]) irq_pend_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Combinational read mux; unused bits read as zero.
    always_comb begin
        rdata = '0;
        case (bus.Addr[3:2])
            2'd0: rdata = {28'd0, im_q, mode_q, en_q};
            2'd1: rdata = 32'(preset_q);
            2'd2: rdata = 32'(count_q);
            2'd3: begin
`ifdef BUS_TIMER_STATUS_EN
                rdata = {27'd0, irq_pend_q, state_q, im_q, en_q};
`else
                rdata = '0;
`endif
            end
            default: rdata = '0;
        endcase
    end

    assign bus.RData = rdata;
    assign bus.IRQ   = im_q & irq_pend_q;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed scoreboard bench for bus_timer (CNT_W=32 and CNT_W=8).
module tb_bus_timer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    bus_timer_if bus ();
    bus_timer_if bus8 ();

    bus_timer #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
    bus_timer #(.CNT_W(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got %h want queued entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: got %h want %h", t, obs, e);
            end
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        bus.Addr  = {28'd0, off};
        bus.WData = d;
        bus.WE    = 1'b1;
        tick();
        bus.WE    = 1'b0;
    endtask

    task automatic rd_cmp(input logic [1:0] off);
        bus.Addr = {28'd0, off};
        #1;
        compare(bus.RData);
    endtask

    task automatic irq_cmp();
        compare({31'd0, bus.IRQ});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.Addr   = '0;
        bus.WData  = '0;
        bus.WE     = 1'b0;
        bus8.Addr  = '0;
        bus8.WData = '0;
        bus8.WE    = 1'b0;

        // Reset held 2 clk with writes pending: nothing may be written.
        bus.WE     = 1'b1;
        bus.Addr   = 30'd0;
        bus.WData  = 32'h0000_000F;
        bus8.WE    = 1'b1;
        bus8.Addr  = 30'd1;
        bus8.WData = 32'h0000_00FF;
        tick();
        bus.Addr  = 30'd1;
        bus.WData = 32'hFFFF_FFFF;
        tick();
        reset   = 1'b0;
        bus.WE  = 1'b0;
        bus8.WE = 1'b0;
        for (int o = 0; o < 4; o++) begin
            expect_val("reset_rdata", 32'd0);
            rd_cmp(2'(o));
        end
        expect_val("reset_irq", 32'd0);
        irq_cmp();
        bus8.Addr = 30'd1;
        #1;
        expect_val("reset_preset8", 32'd0);
        compare(bus8.RData);

        // One-shot: PRESET=5, CTRL=EN|IM.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int v = 5; v >= 0; v--) expect_val("oneshot_count", 32'(v));
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k >= 2) rd_cmp(2'd2);
            if (k == 6) begin expect_val("oneshot_irq_pre", 32'd0); irq_cmp(); end
            if (k == 7) begin expect_val("oneshot_irq_rise", 32'd1); irq_cmp(); end
        end
        tick();
        expect_val("oneshot_ctrl_en_cleared", 32'h8);
        rd_cmp(2'd0);
        tick();
        tick();
        expect_val("oneshot_irq_held", 32'd1);
        irq_cmp();
        wr(2'd0, 32'h8);
        expect_val("oneshot_irq_ack", 32'd0);
        irq_cmp();

        // Auto-reload: PRESET=3, CTRL=EN|RELOAD|IM -> 1-clk IRQ every 6 clk.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 24; k++) begin
            tick();
            expect_val("reload_irq", (k >= 5 && (k - 5) % 6 == 0) ? 32'd1 : 32'd0);
            irq_cmp();
        end
        expect_val("reload_ctrl", 32'hB);
        rd_cmp(2'd0);
        wr(2'd0, 32'h0);
        tick(); tick(); tick();

        // Pause: EN dropped as COUNT reaches 6, then restart reloads PRESET.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        tick(); tick(); tick(); tick(); tick();
        expect_val("pause_count7", 32'd7);
        rd_cmp(2'd2);
        wr(2'd0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            expect_val("pause_hold", 32'd6);
            rd_cmp(2'd2);
            tick();
        end
        wr(2'd0, 32'h1);
        tick();
        tick();
        expect_val("pause_reload", 32'd10);
        rd_cmp(2'd2);
        wr(2'd0, 32'h0);
        tick(); tick();

        // Masked expiry: IM=0 keeps IRQ low while irq_pend still sets.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 4) begin expect_val("masked_irq", 32'd0); irq_cmp(); end
        end
`ifdef BUS_TIMER_STATUS_EN
        expect_val("status_pend", 32'h10);
        rd_cmp(2'd3);
        wr(2'd3, 32'h4);
        expect_val("status_clear", 32'h0);
        rd_cmp(2'd3);
`else
        expect_val("status_off", 32'h0);
        rd_cmp(2'd3);
        wr(2'd3, 32'hFFFF_FFFF);
        expect_val("status_wr_ignored", 32'h0);
        rd_cmp(2'd0);
`endif

        // Collision A: CTRL write in the INT cycle keeps the written value.
        wr(2'd0, 32'h9);
        tick(); tick(); tick(); tick();
        expect_val("colA_int_irq", 32'd1);
        irq_cmp();
        wr(2'd0, 32'h9);
        expect_val("colA_ctrl", 32'h9);
        rd_cmp(2'd0);
        expect_val("colA_irq", 32'd0);
        irq_cmp();
        wr(2'd0, 32'h0);
        tick(); tick(); tick();

        // Collision B: CTRL write on the expiry edge beats the irq_pend set.
        wr(2'd0, 32'h9);
        tick(); tick(); tick();
        wr(2'd0, 32'h9);
        expect_val("colB_irq", 32'd0);
        irq_cmp();
        tick();
        expect_val("colB_ctrl_after_int", 32'h8);
        rd_cmp(2'd0);
        expect_val("colB_irq_after", 32'd0);
        irq_cmp();

        // PRESET=0 expires 3 clk after EN.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        tick();
        expect_val("p0_irq_k2", 32'd0);
        irq_cmp();
        tick();
        expect_val("p0_irq_k3", 32'd1);
        irq_cmp();
        wr(2'd0, 32'h8);
        expect_val("p0_irq_ack", 32'd0);
        irq_cmp();

        // COUNT is read-only.
        wr(2'd1, 32'd7);
        wr(2'd2, 32'h1234);
        expect_val("count_ro", 32'd0);
        rd_cmp(2'd2);
        expect_val("count_wr_preset", 32'd7);
        rd_cmp(2'd1);

        // CNT_W=8 truncates PRESET writes.
        bus8.Addr  = 30'd1;
        bus8.WData = 32'h0000_01FF;
        bus8.WE    = 1'b1;
        tick();
        bus8.WE    = 1'b0;
        #1;
        expect_val("preset8_trunc", 32'h0000_00FF);
        compare(bus8.RData);

        // Reset mid-count with a write pending.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(); tick(); tick();
        reset     = 1'b1;
        bus.Addr  = 30'd0;
        bus.WData = 32'hF;
        bus.WE    = 1'b1;
        tick();
        reset  = 1'b0;
        bus.WE = 1'b0;
        for (int o = 0; o < 4; o++) begin
            expect_val("midreset_rdata", 32'd0);
            rd_cmp(2'(o));
        end
        expect_val("midreset_irq", 32'd0);
        irq_cmp();
        tick(); tick(); tick();
        expect_val("midreset_idle_count", 32'd0);
        rd_cmp(2'd2);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
